// File: rtl/sys_ctrl_gen_if.sv
// sys_ctrl_gen_if: frame input, register-file, ALU and TX FIFO signals of the
// system controller.
//   master : frame source plus the register file / ALU / FIFO responders
//   slave  : controller side (sys_ctrl_gen)
interface sys_ctrl_gen_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) ();
  localparam int unsigned AW = $clog2(DEPTH);

  logic               data_valid;
  logic [WIDTH-1:0]   p_data;
  logic               FIFO_FULL;
  logic [2*WIDTH-1:0] ALU_OUT;
  logic               OUT_Valid;
  logic [WIDTH-1:0]   Rd_D;
  logic               Rd_D_Vld;
  logic               WrEn;
  logic               RdEn;
  logic [AW-1:0]      Addr;
  logic [WIDTH-1:0]   Wr_D;
  logic [3:0]         FUN;
  logic               EN;
  logic               Gate_EN;
  logic [WIDTH-1:0]   WR_DATA;
  logic               WR_INC;
  logic               busy;
  logic               err;
  logic [1:0]         err_code;

  modport master (
    output data_valid, p_data, FIFO_FULL, ALU_OUT, OUT_Valid, Rd_D, Rd_D_Vld,
    input  WrEn, RdEn, Addr, Wr_D, FUN, EN, Gate_EN, WR_DATA, WR_INC,
           busy, err, err_code
  );

  modport slave (
    input  data_valid, p_data, FIFO_FULL, ALU_OUT, OUT_Valid, Rd_D, Rd_D_Vld,
    output WrEn, RdEn, Addr, Wr_D, FUN, EN, Gate_EN, WR_DATA, WR_INC,
           busy, err, err_code
  );
endinterface

// File: rtl/sys_ctrl_gen.sv
// sys_ctrl_gen: decodes command frames into register-file writes/reads, ALU
// operations and burst reads, pushing results into a TX FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sys_ctrl_gen_if slave (frames in, reg/ALU/FIFO strobes out)
// All outputs are registered; strobes are single-cycle pulses.
module sys_ctrl_gen #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic           clk,
  input  logic           rst,
  sys_ctrl_gen_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, BST_ADDR, BST_CNT, OP_A, OP_B,
    ALU_FUN, ALU_WAIT, RD_REQ, RD_WAIT, TX_RD, TX_LO, TX_HI
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    lat_addr_q, lat_addr_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wr_d_q, wr_d_d;
  logic [3:0]       fun_q, fun_d;
  logic             en_q, en_d, gate_en_q, gate_en_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             wr_inc_q, wr_inc_d, busy_q, busy_d, err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             arg_st_c;
  logic             addr_ok_c;
  logic             cnt_bad_c;
  logic [AW-1:0]    p_addr_c;
  logic [AW-1:0]    next_addr_c;

  // Frame qualifiers shared by several states
  always_comb begin
    arg_st_c    = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, BST_ADDR, BST_CNT,
                                  OP_A, OP_B, ALU_FUN};
    addr_ok_c   = 32'(bus.p_data) < DEPTH;
    cnt_bad_c   = (bus.p_data == '0) || (32'(bus.p_data) > MAX_BURST);
    p_addr_c    = AW'(bus.p_data);
    next_addr_c = (lat_addr_q == AW'(DEPTH - 1)) ? '0 : lat_addr_q + AW'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    cnt_d      = cnt_q;
    tmo_d      = '0;
    data_d     = data_q;
    hi_d       = hi_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    wr_d_d     = wr_d_q;
    fun_d      = fun_q;
    wr_data_d  = wr_data_q;
    wr_inc_d   = 1'b0;
    err_d      = 1'b0;
    err_code_d = 2'b00;

    // Idle time between argument frames; a frame always clears it
    if (arg_st_c && !bus.data_valid) begin
      if (tmo_q == TW'(TIMEOUT)) begin
        err_d      = 1'b1;
        err_code_d = 2'b11;
        state_d    = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    case (state_q)
      IDLE: if (bus.data_valid) begin
        case (bus.p_data)
          WIDTH'(8'hAA): state_d = WR_ADDR;
          WIDTH'(8'hBB): state_d = RD_ADDR;
          WIDTH'(8'hCC): state_d = OP_A;
          WIDTH'(8'hDD): state_d = ALU_FUN;
          WIDTH'(8'hEE): state_d = BST_ADDR;
          default: begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end
        endcase
      end
      WR_ADDR, RD_ADDR, BST_ADDR: if (bus.data_valid) begin
        if (!addr_ok_c) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = IDLE;
        end else begin
          lat_addr_d = p_addr_c;
          if (state_q == WR_ADDR) begin
            state_d = WR_DATA;
          end else if (state_q == BST_ADDR) begin
            state_d = BST_CNT;
          end else begin
            cnt_d   = WIDTH'(1);
            rd_en_d = 1'b1;
            addr_d  = p_addr_c;
            state_d = RD_REQ;
          end
        end
      end
      WR_DATA: if (bus.data_valid) begin
        wr_en_d = 1'b1;
        addr_d  = lat_addr_q;
        wr_d_d  = bus.p_data;
        state_d = IDLE;
      end
      BST_CNT: if (bus.data_valid) begin
        if (cnt_bad_c) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = IDLE;
        end else begin
          cnt_d   = bus.p_data;
          rd_en_d = 1'b1;
          addr_d  = lat_addr_q;
          state_d = RD_REQ;
        end
      end
      // Operands land in registers 0 and 1 ahead of the ALU function
      OP_A, OP_B: if (bus.data_valid) begin
        wr_en_d = 1'b1;
        addr_d  = (state_q == OP_A) ? '0 : AW'(1);
        wr_d_d  = bus.p_data;
        state_d = (state_q == OP_A) ? OP_B : ALU_FUN;
      end
      ALU_FUN: if (bus.data_valid) begin
        fun_d   = bus.p_data[3:0];
        state_d = ALU_WAIT;
      end
      ALU_WAIT: if (bus.OUT_Valid) begin
        data_d  = bus.ALU_OUT[WIDTH-1:0];
        hi_d    = bus.ALU_OUT[2*WIDTH-1:WIDTH];
        state_d = TX_LO;
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: if (bus.Rd_D_Vld) begin
        data_d  = bus.Rd_D;
        state_d = TX_RD;
      end
      // WR_DATA only changes together with a push, so it is stable while full
      TX_RD: if (!bus.FIFO_FULL) begin
        wr_inc_d  = 1'b1;
        wr_data_d = data_q;
        if (cnt_q > WIDTH'(1)) begin
          cnt_d      = cnt_q - WIDTH'(1);
          lat_addr_d = next_addr_c;
          rd_en_d    = 1'b1;
          addr_d     = next_addr_c;
          state_d    = RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      TX_LO: if (!bus.FIFO_FULL) begin
        wr_inc_d  = 1'b1;
        wr_data_d = data_q;
        state_d   = TX_HI;
      end
      TX_HI: if (!bus.FIFO_FULL) begin
        wr_inc_d  = 1'b1;
        wr_data_d = hi_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Frames arriving while the controller is not expecting one are dropped
    if (!arg_st_c && (state_q != IDLE) && bus.data_valid) begin
      err_d      = 1'b1;
      err_code_d = 2'b00;
    end
  end

  always_comb begin
    en_d      = state_d inside {ALU_WAIT, TX_LO, TX_HI};
    gate_en_d = en_d;
    busy_d    = state_d != IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_addr_q <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      data_q     <= '0;
      hi_q       <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_d_q     <= '0;
      fun_q      <= '0;
      en_q       <= 1'b0;
      gate_en_q  <= 1'b0;
      wr_data_q  <= '0;
      wr_inc_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      hi_q       <= hi_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wr_d_q     <= wr_d_d;
      fun_q      <= fun_d;
      en_q       <= en_d;
      gate_en_q  <= gate_en_d;
      wr_data_q  <= wr_data_d;
      wr_inc_q   <= wr_inc_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.WrEn     = wr_en_q;
  assign bus.RdEn     = rd_en_q;
  assign bus.Addr     = addr_q;
  assign bus.Wr_D     = wr_d_q;
  assign bus.FUN      = fun_q;
  assign bus.EN       = en_q;
  assign bus.Gate_EN  = gate_en_q;
  assign bus.WR_DATA  = wr_data_q;
  assign bus.WR_INC   = wr_inc_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
endmodule
